uart_cmd_responder: RTL

Byte-level command responder on the host side of the UART's receive/transmit byte streams. It consumes command frames from the UART receive side (rx_valid/rx_ready), performs single-byte reads and writes on a simple 8-bit register bus, and returns one response byte per command on the UART transmit side (tx_valid/tx_ready). It is the target end of the host-initiated serial link and gives the host peek/poke access to on-chip registers.

---
 rtl/uart_cmd_responder_if.sv | 25 ++
 rtl/uart_cmd_responder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder_if.sv
// Byte-stream and register-bus signals of the UART command responder.
// The responder sits on the slave side; the UART and the register file sit on the master side.
interface uart_cmd_responder_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  modport master (
    output rx_byte, rx_valid, tx_ready, mem_rdata,
    input  rx_ready, tx_byte, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  rx_byte, rx_valid, tx_ready, mem_rdata,
    output rx_ready, tx_byte, tx_valid, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART-side command responder: 'W' addr data -> register write, 'R' addr -> register read,
// one response byte per frame; partial frames are abandoned after TIMEOUT_CYCLES idle cycles.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                       clock,
  input  logic                       reset,
  uart_cmd_responder_if.slave        bus,
  output logic                       timeout
);

  localparam logic [7:0]  OpWrite   = 8'h57;
  localparam logic [7:0]  OpRead    = 8'h52;
  localparam logic [7:0]  RespOk    = 8'h4B;
  localparam logic [7:0]  RespError = 8'h3F;
  localparam logic [19:0] CntLast   = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StData, StWrite, StRead, StRwait, StResp
  } state_e;

  state_e      state_q;
  logic        write_op_q;
  logic [19:0] cnt_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic [7:0]  mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic        timeout_q;
  logic        rx_ready;
  logic        accept;

  // Gated by reset so nothing is taken while the block is being cleared.
  always_comb begin
    rx_ready = 1'b0;
    if (!reset) begin
      rx_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StData);
    end
  end

  assign accept = rx_ready && bus.rx_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      write_op_q  <= 1'b0;
      cnt_q       <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.rx_byte == OpWrite) begin
              write_op_q <= 1'b1;
              state_q    <= StAddr;
            end else if (bus.rx_byte == OpRead) begin
              write_op_q <= 1'b0;
              state_q    <= StAddr;
            end else begin
              tx_byte_q  <= RespError;
              tx_valid_q <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StAddr, StData: begin
          // An accept on the expiry cycle takes priority over the timeout.
          if (accept) begin
            if (state_q == StAddr) begin
              mem_addr_q <= bus.rx_byte;
              if (write_op_q) begin
                state_q <= StData;
              end else begin
                mem_re_q <= 1'b1;
                state_q  <= StRead;
              end
            end else begin
              mem_wdata_q <= bus.rx_byte;
              mem_we_q    <= 1'b1;
              state_q     <= StWrite;
            end
          end else if (cnt_q == CntLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        StWrite: begin
          tx_byte_q  <= RespOk;
          tx_valid_q <= 1'b1;
          state_q    <= StResp;
        end
        StRead: begin
          state_q <= StRwait;
        end
        StRwait: begin
          tx_byte_q  <= bus.mem_rdata;
          tx_valid_q <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign timeout       = timeout_q;

endmodule
